// File: rtl/main_sort.sv
// rtl/main_sort.sv - Avalon-ST packet sorter (ascending, unsigned, one packet at a time)
//
// Ports:
//   clk_i                 clock, rising edge
//   srst_i                asynchronous active-high reset
//   snk_data_i            sink word
//   snk_startofpacket_i   sink first word of packet
//   snk_endofpacket_i     sink last word of packet
//   snk_valid_i           sink word valid
//   snk_ready_o           sorter can accept a sink word
//   src_data_o            source word
//   src_startofpacket_o   source first word of packet
//   src_endofpacket_o     source last word of packet
//   src_valid_o           source word valid
//   src_ready_i           downstream accepts source word

module main_sort #(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
);

    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int IW = $clog2(MAX_PKT_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        SORT = 2'd2,
        TX   = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     phase;
    logic [IW-1:0]     tx_idx;

    logic [DWIDTH-1:0] mem       [MAX_PKT_LEN];
    logic [DWIDTH-1:0] sort_next [MAX_PKT_LEN];

    logic              snk_xfer;
    logic              src_xfer;
    logic              wr_en;
    logic [IW-1:0]     wr_addr;

    assign snk_xfer = snk_valid_i & snk_ready_o;
    assign src_xfer = src_valid_o & src_ready_i;

    // A start-of-packet word always lands in slot 0, both from IDLE and as a
    // restart inside RX. In IDLE a word without sop is simply not stored.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (snk_xfer) begin
            if (snk_startofpacket_i) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state == RX) begin
                wr_en   = 1'b1;
                wr_addr = cnt[IW-1:0];
            end
        end
    end

    // One odd-even transposition phase: even phases compare (0,1),(2,3)...,
    // odd phases compare (1,2),(3,4).... Pairs are disjoint, so every swap
    // reads only the current storage. Pairs reaching past cnt-1 are left alone.
    always_comb begin
        sort_next = mem;
        for (int i = 0; i < MAX_PKT_LEN - 1; i++) begin
            if (((i % 2) == int'(phase[0])) && ((i + 1) < int'(cnt)) &&
                (mem[i] > mem[i+1])) begin
                sort_next[i]   = mem[i+1];
                sort_next[i+1] = mem[i];
            end
        end
    end

    // Storage carries no reset; its contents are meaningless until a packet
    // has been written.
    always_ff @(posedge clk_i) begin
        if (state == SORT) begin
            mem <= sort_next;
        end else if (wr_en) begin
            mem[wr_addr] <= snk_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state               <= IDLE;
            cnt                 <= '0;
            phase               <= '0;
            tx_idx              <= '0;
            snk_ready_o         <= 1'b0;
            src_data_o          <= '0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            src_valid_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    snk_ready_o <= 1'b1;
                    if (snk_xfer && snk_startofpacket_i) begin
                        cnt <= CW'(1);
                        if (snk_endofpacket_i) begin
                            state       <= SORT;
                            phase       <= '0;
                            snk_ready_o <= 1'b0;
                        end else begin
                            state <= RX;
                        end
                    end
                end

                RX: begin
                    if (snk_xfer) begin
                        if (snk_startofpacket_i) begin
                            cnt <= CW'(1);
                            if (snk_endofpacket_i) begin
                                state       <= SORT;
                                phase       <= '0;
                                snk_ready_o <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                            // A full buffer closes the packet even without eop.
                            if (snk_endofpacket_i || (cnt == CW'(MAX_PKT_LEN - 1))) begin
                                state       <= SORT;
                                phase       <= '0;
                                snk_ready_o <= 1'b0;
                            end
                        end
                    end
                end

                SORT: begin
                    phase <= phase + IW'(1);
                    if (phase == IW'(MAX_PKT_LEN - 1)) begin
                        // The final phase is written to storage on this same
                        // edge, so word 0 is taken from the sorter output.
                        state               <= TX;
                        tx_idx              <= '0;
                        src_valid_o         <= 1'b1;
                        src_data_o          <= sort_next[0];
                        src_startofpacket_o <= 1'b1;
                        src_endofpacket_o   <= (cnt == CW'(1));
                    end
                end

                TX: begin
                    if (src_xfer) begin
                        if (src_endofpacket_o) begin
                            state               <= IDLE;
                            cnt                 <= '0;
                            src_valid_o         <= 1'b0;
                            src_data_o          <= '0;
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= 1'b0;
                            snk_ready_o         <= 1'b1;
                        end else begin
                            tx_idx              <= tx_idx + IW'(1);
                            src_data_o          <= mem[tx_idx + IW'(1)];
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= ((CW'(tx_idx) + CW'(2)) == cnt);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_sort.sv
// tb/tb_main_sort.sv - directed self-checking bench for main_sort

module tb_main_sort;

    localparam int DW  = 8;
    localparam int MAX = 16;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b1;
    logic [DW-1:0] snk_data_i = '0;
    logic          snk_startofpacket_i = 1'b0;
    logic          snk_endofpacket_i = 1'b0;
    logic          snk_valid_i = 1'b0;
    logic          snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;
    logic          src_ready_i = 1'b0;

    main_sort #(.DWIDTH(DW), .MAX_PKT_LEN(MAX)) dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] tx_words  [64];
    logic [DW-1:0] exp_words [64];
    logic [DW-1:0] rx_data   [64];
    bit            rx_sop    [64];
    bit            rx_eop    [64];
    int            rx_n, stall_err, ready_err, t_last, t_first;
    bit            rx_done, drv_done, eop_ready;

    task automatic drive_pkt(input int n, input int pct, input bit with_eop);
        int idx = 0;
        int guard = 0;
        bit rdy = 1'b0;
        t_last = -1;
        while (idx < n && guard < 4000) begin
            @(negedge clk_i);
            guard++;
            if (snk_valid_i && rdy) begin
                idx++;
                if (idx == n) t_last = cyc;
            end
            if (idx < n && $urandom_range(99) < pct) begin
                snk_valid_i         = 1'b1;
                snk_data_i          = tx_words[idx];
                snk_startofpacket_i = (idx == 0);
                snk_endofpacket_i   = with_eop && (idx == n - 1);
            end else begin
                snk_valid_i = 1'b0;
            end
            rdy = snk_ready_o;
        end
        snk_valid_i = 1'b0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0;
        drv_done = (idx == n);
    endtask

    task automatic collect(input int pct);
        bit prev_stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic ps = 1'b0, pe = 1'b0;
        int guard = 0;
        rx_n = 0; stall_err = 0; ready_err = 0; t_first = -1; rx_done = 1'b0;
        while (!rx_done && guard < 4000) begin
            @(negedge clk_i);
            guard++;
            if (prev_stall && (src_valid_o !== 1'b1 || src_data_o !== pd ||
                src_startofpacket_o !== ps || src_endofpacket_o !== pe))
                stall_err++;
            if (src_valid_o === 1'b1 && snk_ready_o === 1'b1) ready_err++;
            if (rx_n == 0 && t_last >= 0 && src_valid_o !== 1'b1 && snk_ready_o === 1'b1)
                ready_err++;
            src_ready_i = ($urandom_range(99) < pct);
            if (src_valid_o === 1'b1) begin
                if (t_first < 0) t_first = cyc;
                if (src_ready_i) begin
                    if (rx_n < 64) begin
                        rx_data[rx_n] = src_data_o;
                        rx_sop[rx_n]  = src_startofpacket_o;
                        rx_eop[rx_n]  = src_endofpacket_o;
                    end
                    rx_n++;
                    if (src_endofpacket_o === 1'b1) rx_done = 1'b1;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    pd = src_data_o; ps = src_startofpacket_o; pe = src_endofpacket_o;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
        @(negedge clk_i);
        eop_ready = snk_ready_o;
        src_ready_i = 1'b0;
    endtask

    task automatic run_pkt(input int n, input int vpct, input int rpct);
        fork
            drive_pkt(n, vpct, 1'b1);
            collect(rpct);
        join
    endtask

    task automatic test_reset;
        srst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (snk_ready_o !== 1'b0) begin failures++; $display("FAIL rst_snk_ready got=%b exp=0", snk_ready_o); end
        checks++; if (src_valid_o !== 1'b0) begin failures++; $display("FAIL rst_src_valid got=%b exp=0", src_valid_o); end
        checks++; if (src_data_o !== 8'h00) begin failures++; $display("FAIL rst_src_data got=%h exp=00", src_data_o); end
        checks++; if (src_startofpacket_o !== 1'b0) begin failures++; $display("FAIL rst_src_sop got=%b exp=0", src_startofpacket_o); end
        checks++; if (src_endofpacket_o !== 1'b0) begin failures++; $display("FAIL rst_src_eop got=%b exp=0", src_endofpacket_o); end
        srst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (snk_ready_o !== 1'b1) begin failures++; $display("FAIL idle_snk_ready got=%b exp=1", snk_ready_o); end
    endtask

    task automatic test_basic;
        tx_words[0] = 8'd5; tx_words[1] = 8'd3; tx_words[2] = 8'd9; tx_words[3] = 8'd1;
        exp_words[0] = 8'd1; exp_words[1] = 8'd3; exp_words[2] = 8'd5; exp_words[3] = 8'd9;
        run_pkt(4, 100, 100);
        checks++; if (!rx_done || rx_n !== 4) begin failures++; $display("FAIL basic_len got=%0d exp=4 done=%b", rx_n, rx_done); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data[i] !== exp_words[i] || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_word[%0d] got=%h/%b/%b exp=%h/%b/%b", i, rx_data[i], rx_sop[i], rx_eop[i], exp_words[i], i == 0, i == 3);
            end
        end
        checks++; if (ready_err !== 0) begin failures++; $display("FAIL basic_snk_ready_busy got=%0d cycles exp=0", ready_err); end
        checks++; if (t_first - t_last > MAX + 2 || t_first <= t_last) begin failures++; $display("FAIL basic_latency got=%0d exp<=%0d", t_first - t_last, MAX + 2); end
        checks++; if (eop_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_eop got=%b exp=1", eop_ready); end
    endtask

    task automatic test_lengths;
        tx_words[0] = 8'hFF; tx_words[1] = 8'h00;
        run_pkt(2, 100, 100);
        checks++; if (rx_n !== 2) begin failures++; $display("FAIL len2_len got=%0d exp=2", rx_n); end
        checks++;
        if (rx_data[0] !== 8'h00 || rx_data[1] !== 8'hFF || rx_sop[0] !== 1'b1 || rx_eop[1] !== 1'b1 || rx_eop[0] !== 1'b0) begin
            failures++;
            $display("FAIL len2_words got=%h,%h sop0=%b eop0=%b eop1=%b exp=00,FF 1 0 1", rx_data[0], rx_data[1], rx_sop[0], rx_eop[0], rx_eop[1]);
        end
        for (int i = 0; i < MAX; i++) tx_words[i] = 8'(15 - i);
        run_pkt(MAX, 100, 100);
        checks++; if (rx_n !== MAX) begin failures++; $display("FAIL lenmax_len got=%0d exp=%0d", rx_n, MAX); end
        for (int i = 0; i < MAX; i++) begin
            checks++;
            if (rx_data[i] !== 8'(i) || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == MAX - 1)) begin
                failures++;
                $display("FAIL lenmax_word[%0d] got=%h/%b/%b exp=%h", i, rx_data[i], rx_sop[i], rx_eop[i], 8'(i));
            end
        end
    endtask

    task automatic test_dups_single;
        tx_words[0] = 8'd7; tx_words[1] = 8'd7; tx_words[2] = 8'd2; tx_words[3] = 8'd7; tx_words[4] = 8'd2;
        exp_words[0] = 8'd2; exp_words[1] = 8'd2; exp_words[2] = 8'd7; exp_words[3] = 8'd7; exp_words[4] = 8'd7;
        run_pkt(5, 100, 100);
        checks++; if (rx_n !== 5) begin failures++; $display("FAIL dups_len got=%0d exp=5", rx_n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_data[i] !== exp_words[i]) begin failures++; $display("FAIL dups_word[%0d] got=%h exp=%h", i, rx_data[i], exp_words[i]); end
        end
        tx_words[0] = 8'h0A;
        run_pkt(1, 100, 100);
        checks++;
        if (rx_n !== 1 || rx_data[0] !== 8'h0A || rx_sop[0] !== 1'b1 || rx_eop[0] !== 1'b1) begin
            failures++;
            $display("FAIL single got n=%0d d=%h sop=%b eop=%b exp n=1 d=0A sop=1 eop=1", rx_n, rx_data[0], rx_sop[0], rx_eop[0]);
        end
    endtask

    task automatic test_random;
        int vp[8] = '{10, 25, 50, 75, 100, 40, 90, 100};
        int rp[8] = '{20, 50, 100, 35, 60, 100, 10, 80};
        int n;
        logic [DW-1:0] tmp;
        for (int p = 0; p < 8; p++) begin
            n = (p == 0) ? 2 : (p == 1) ? MAX : $urandom_range(MAX, 2);
            for (int i = 0; i < n; i++) begin
                tx_words[i]  = 8'($urandom);
                exp_words[i] = tx_words[i];
            end
            for (int i = 1; i < n; i++)
                for (int j = i; j > 0 && exp_words[j-1] > exp_words[j]; j--) begin
                    tmp = exp_words[j]; exp_words[j] = exp_words[j-1]; exp_words[j-1] = tmp;
                end
            run_pkt(n, vp[p], rp[p]);
            checks++; if (rx_n !== n || !drv_done) begin failures++; $display("FAIL rand%0d_len got=%0d exp=%0d drv=%b", p, rx_n, n, drv_done); end
            checks++; if (stall_err !== 0) begin failures++; $display("FAIL rand%0d_stable got=%0d changes exp=0", p, stall_err); end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rx_data[i] !== exp_words[i] || rx_eop[i] !== (i == n - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_word[%0d] got=%h eop=%b exp=%h", p, i, rx_data[i], rx_eop[i], exp_words[i]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < MAX + 3; i++) tx_words[i] = 8'(MAX + 2 - i);
        fork
            begin
                drive_pkt(MAX, 100, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_i);
                    snk_valid_i = 1'b1;
                    snk_data_i = tx_words[MAX + k];
                    snk_endofpacket_i = (k == 2);
                    checks++;
                    if (snk_ready_o !== 1'b0) begin failures++; $display("FAIL ovf_refuse[%0d] got=%b exp=0", k, snk_ready_o); end
                end
                @(negedge clk_i);
                snk_valid_i = 1'b0;
                snk_endofpacket_i = 1'b0;
            end
            collect(100);
        join
        checks++; if (rx_n !== MAX) begin failures++; $display("FAIL ovf_len got=%0d exp=%0d", rx_n, MAX); end
        for (int i = 0; i < MAX; i++) begin
            checks++;
            if (rx_data[i] !== 8'(i + 3)) begin failures++; $display("FAIL ovf_word[%0d] got=%h exp=%h", i, rx_data[i], 8'(i + 3)); end
        end
    endtask

    task automatic test_reset_abort;
        int guard = 0;
        for (int i = 0; i < 6; i++) tx_words[i] = 8'(60 - i);
        drive_pkt(3, 100, 1'b0);
        #2 srst_i = 1'b1;
        #1;
        checks++; if (snk_ready_o !== 1'b0 || src_valid_o !== 1'b0) begin failures++; $display("FAIL rx_abort got ready=%b valid=%b exp=0,0", snk_ready_o, src_valid_o); end
        @(negedge clk_i) srst_i = 1'b0;
        tx_words[0] = 8'd4; tx_words[1] = 8'd3; tx_words[2] = 8'd2; tx_words[3] = 8'd1;
        run_pkt(4, 100, 100);
        checks++;
        if (rx_n !== 4 || rx_data[0] !== 8'd1 || rx_data[1] !== 8'd2 || rx_data[2] !== 8'd3 || rx_data[3] !== 8'd4) begin
            failures++;
            $display("FAIL after_rx_abort got n=%0d %h,%h,%h,%h exp 4 01,02,03,04", rx_n, rx_data[0], rx_data[1], rx_data[2], rx_data[3]);
        end
        tx_words[0] = 8'd8; tx_words[1] = 8'd6; tx_words[2] = 8'd7; tx_words[3] = 8'd5;
        src_ready_i = 1'b0;
        drive_pkt(4, 100, 1'b1);
        while (src_valid_o !== 1'b1 && guard < 100) begin @(negedge clk_i); guard++; end
        checks++; if (src_valid_o !== 1'b1 || src_data_o !== 8'd5) begin failures++; $display("FAIL tx_before_abort got valid=%b data=%h exp=1,05", src_valid_o, src_data_o); end
        #2 srst_i = 1'b1;
        #1;
        checks++;
        if (src_valid_o !== 1'b0 || src_data_o !== 8'h00 || src_startofpacket_o !== 1'b0 || snk_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL tx_abort got valid=%b data=%h sop=%b ready=%b exp=0,00,0,0", src_valid_o, src_data_o, src_startofpacket_o, snk_ready_o);
        end
        @(negedge clk_i) srst_i = 1'b0;
        tx_words[0] = 8'd30; tx_words[1] = 8'd10; tx_words[2] = 8'd20;
        run_pkt(3, 100, 100);
        checks++;
        if (rx_n !== 3 || rx_data[0] !== 8'd10 || rx_data[1] !== 8'd20 || rx_data[2] !== 8'd30) begin
            failures++;
            $display("FAIL after_tx_abort got n=%0d %h,%h,%h exp 3 0a,14,1e", rx_n, rx_data[0], rx_data[1], rx_data[2]);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_lengths;
        test_dups_single;
        test_random;
        test_overflow;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
